// File: rtl/rs232_tx_arbiter.sv
// rs232_tx_arbiter: round-robin sharing of one RS-232 byte transmitter
// between NUM_REQ requesters. A packet lock keeps multi-byte messages from
// one requester contiguous. Optional HOLD stall timeout is compiled in when
// the macro ARB_TIMEOUT_EN is defined (adds output port timeout_evt_o).
//
// state        | meaning
// ST_ARB       | idle; grant first valid requester at/after rr_ptr
// ST_SEND      | start strobe to the transmitter (one cycle)
// ST_WAIT_BUSY | waiting for transmitter busy to rise (gives up after 2)
// ST_WAIT_DONE | character in flight; waiting for busy to fall
// ST_HOLD      | packet locked to active_id; waiting for its next byte
module rs232_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int ID_WIDTH       = 2,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic [NUM_REQ-1:0]    req_valid_i,
   input  logic [NUM_REQ-1:0]    req_last_i,
   input  logic [8*NUM_REQ-1:0]  req_data_i,
   output logic [NUM_REQ-1:0]    req_ready_o,
   input  logic                  abort_i,
   input  logic                  tx_busy_i,
   output logic [7:0]            tx_datain_o,
   output logic                  tx_datain_ready_o,
   output logic                  tx_abort_o,
   output logic [ID_WIDTH-1:0]   active_id_o,
`ifdef ARB_TIMEOUT_EN
   output logic                  timeout_evt_o,
`endif
   output logic                  arb_busy_o
);

   typedef enum logic [2:0] {
      ST_ARB,
      ST_SEND,
      ST_WAIT_BUSY,
      ST_WAIT_DONE,
      ST_HOLD
   } state_t;

   if (NUM_REQ < 2 || NUM_REQ > 8 || (2 ** ID_WIDTH) < NUM_REQ || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("rs232_tx_arbiter: illegal parameter combination");
   end

   state_t              state_q;
   logic [ID_WIDTH-1:0] rr_ptr_q;
   logic [ID_WIDTH-1:0] active_id_q;
   logic                lock_q;
   logic [7:0]          tx_datain_q;
   logic                tx_datain_ready_q;
   logic                wb_cnt_q;

   logic                win_found;
   logic [ID_WIDTH-1:0] win_id;
   logic                accept;
   logic [ID_WIDTH-1:0] acc_id;
   logic [7:0]          acc_data;
   logic                acc_last;
   logic [ID_WIDTH-1:0] rr_ptr_d;

`ifdef ARB_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0] to_cnt_q;
   logic            timeout_evt_q;
`endif

   // pointer value that makes the requester just served lowest priority
   function automatic logic [ID_WIDTH-1:0] next_id(input logic [ID_WIDTH-1:0] id);
      if (int'(id) == NUM_REQ - 1) return '0;
      return id + ID_WIDTH'(1);
   endfunction

   assign rr_ptr_d = next_id(active_id_q);

   // round-robin search: first valid requester at or after rr_ptr, wrapping
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         int idx;
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!win_found && req_valid_i[idx]) begin
            win_found = 1'b1;
            win_id    = idx[ID_WIDTH-1:0];
         end
      end
   end

   // accept decision; in HOLD only the locked requester may be taken
   always_comb begin
      accept = 1'b0;
      acc_id = win_id;
      if (!abort_i && !tx_busy_i) begin
         if (state_q == ST_ARB) begin
            accept = win_found;
         end else if (state_q == ST_HOLD) begin
            acc_id = active_id_q;
            accept = req_valid_i[active_id_q];
         end
      end
   end

   assign acc_data    = req_data_i[8*int'(acc_id) +: 8];
   assign acc_last    = req_last_i[acc_id];
   assign req_ready_o = accept ? (NUM_REQ'(1) << acc_id) : '0;

   // main sequencer: grant, strobe, track busy through the character
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q           <= ST_ARB;
         rr_ptr_q          <= '0;
         active_id_q       <= '0;
         lock_q            <= 1'b0;
         tx_datain_q       <= 8'hFF;
         tx_datain_ready_q <= 1'b0;
         wb_cnt_q          <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         to_cnt_q          <= TO_LOAD;
         timeout_evt_q     <= 1'b0;
`endif
      end else begin
         tx_datain_ready_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         to_cnt_q          <= TO_LOAD;
         timeout_evt_q     <= 1'b0;
`endif
         if (abort_i) begin
            state_q     <= ST_ARB;
            lock_q      <= 1'b0;
            tx_datain_q <= 8'hFF;
         end else if (accept) begin
            tx_datain_q       <= acc_data;
            active_id_q       <= acc_id;
            lock_q            <= ~acc_last;
            tx_datain_ready_q <= 1'b1;
            state_q           <= ST_SEND;
         end else begin
            case (state_q)
               ST_SEND: begin
                  wb_cnt_q <= 1'b1;
                  state_q  <= ST_WAIT_BUSY;
               end
               ST_WAIT_BUSY: begin
                  // a flushed transmitter may never raise busy; give up after 2 cycles
                  if (tx_busy_i || wb_cnt_q == 1'b0) state_q <= ST_WAIT_DONE;
                  else wb_cnt_q <= 1'b0;
               end
               ST_WAIT_DONE: begin
                  if (!tx_busy_i) begin
                     if (lock_q) begin
                        state_q <= ST_HOLD;
                     end else begin
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= ST_ARB;
                     end
                  end
               end
               ST_HOLD: begin
`ifdef ARB_TIMEOUT_EN
                  if (to_cnt_q == '0) begin
                     lock_q        <= 1'b0;
                     rr_ptr_q      <= rr_ptr_d;
                     timeout_evt_q <= 1'b1;
                     state_q       <= ST_ARB;
                  end else begin
                     to_cnt_q <= to_cnt_q - TO_W'(1);
                  end
`endif
               end
               default: state_q <= ST_ARB;
            endcase
         end
      end
   end

   assign tx_datain_o       = tx_datain_q;
   assign tx_datain_ready_o = tx_datain_ready_q;
   assign tx_abort_o        = abort_i;
   assign active_id_o       = active_id_q;
   assign arb_busy_o        = (state_q != ST_ARB);
`ifdef ARB_TIMEOUT_EN
   assign timeout_evt_o     = timeout_evt_q;
`endif

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Testbench for rs232_tx_arbiter. Requesters are driven from per-requester
// byte queues; the expected grant order is computed from the round-robin /
// packet rules directly on those queues. A small transmitter model raises
// busy for busy_len cycles after each strobe (busy_len = 0: never busy).
module tb_rs232_tx_arbiter;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                clock;
   logic                reset;
   logic                abort;
   logic                tx_busy;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_last;
   logic [NREQ-1:0]     req_ready;
   logic [8*NREQ-1:0]   req_data;
   logic [7:0]          tx_datain;
   logic                tx_datain_ready;
   logic                tx_abort;
   logic                arb_busy;
   logic [IDW-1:0]      active_id;
`ifdef ARB_TIMEOUT_EN
   logic                timeout_evt;
`endif

   rs232_tx_arbiter #(.NUM_REQ(NREQ), .ID_WIDTH(IDW), .TIMEOUT_CYCLES(16)) dut (
      .clock_i           (clock),
      .reset_i           (reset),
      .req_valid_i       (req_valid),
      .req_last_i        (req_last),
      .req_data_i        (req_data),
      .req_ready_o       (req_ready),
      .abort_i           (abort),
      .tx_busy_i         (tx_busy),
      .tx_datain_o       (tx_datain),
      .tx_datain_ready_o (tx_datain_ready),
      .tx_abort_o        (tx_abort),
      .active_id_o       (active_id),
`ifdef ARB_TIMEOUT_EN
      .timeout_evt_o     (timeout_evt),
`endif
      .arb_busy_o        (arb_busy)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int busy_len = 20;

   logic [8:0]  drv_q [NREQ][$];
   logic [9:0]  exp_q[$];
   logic [9:0]  str_log[$];
   int          str_cyc[$];
   int          model_ptr = 0;
   int          rdy_cnt = 0;
   int          rdy_bad = 0;
   int          overlap_cnt = 0;
   int          evt_cnt = 0;
   int          evt_cyc = 0;

   logic [NREQ-1:0] s_ready;
   logic            s_strobe;
   logic [7:0]      s_data;
   logic [IDW-1:0]  s_active;
   logic            s_abort;
   logic            s_arb_busy;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // transmitter model: busy from the cycle after a strobe, flushed by tx_abort
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clock);
         if (tx_datain_ready === 1'b1 && busy_len > 0) begin
            @(posedge clock);
            #1 tx_busy = 1'b1;
            for (int k = 0; k < busy_len; k++) begin
               @(negedge clock);
               if (tx_abort === 1'b1) break;
            end
            @(posedge clock);
            #1 tx_busy = 1'b0;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_reqs();
      logic [8:0] h;
      for (int i = 0; i < NREQ; i++) begin
         if (drv_q[i].size() > 0) begin
            h = drv_q[i][0];
            req_valid[i]       = 1'b1;
            req_last[i]        = h[8];
            req_data[8*i +: 8] = h[7:0];
         end else begin
            req_valid[i]       = 1'b0;
            req_last[i]        = 1'b0;
            req_data[8*i +: 8] = 8'h00;
         end
      end
   endtask

   // one clock: sample outputs at negedge, then update requesters after posedge
   task automatic tick();
      logic [NREQ-1:0] acc;
      @(negedge clock);
      cyc++;
      s_ready    = req_ready;
      s_strobe   = tx_datain_ready;
      s_data     = tx_datain;
      s_active   = active_id;
      s_abort    = tx_abort;
      s_arb_busy = arb_busy;
      if (tx_datain_ready === 1'b1) begin
         if (tx_busy !== 1'b0) overlap_cnt++;
         str_log.push_back({active_id, tx_datain});
         str_cyc.push_back(cyc);
      end
      if (req_ready !== '0) begin
         rdy_cnt++;
         if ($countones(req_ready) != 1) rdy_bad++;
      end
`ifdef ARB_TIMEOUT_EN
      if (timeout_evt === 1'b1) begin
         evt_cnt++;
         evt_cyc = cyc;
      end
`endif
      acc = req_ready;
      @(posedge clock);
      #1;
      for (int i = 0; i < NREQ; i++)
         if (acc[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
      drive_reqs();
   endtask

   function automatic bit all_empty();
      for (int i = 0; i < NREQ; i++) if (drv_q[i].size() > 0) return 1'b0;
      return 1'b1;
   endfunction

   // reference: whole packets in round-robin order over the loaded queues
   task automatic build_expect();
      logic [8:0] mq [NREQ][$];
      logic [8:0] e;
      int sel;
      for (int i = 0; i < NREQ; i++) mq[i] = drv_q[i];
      forever begin
         sel = -1;
         for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (model_ptr + k) % NREQ;
            if (sel < 0 && mq[i].size() > 0) sel = i;
         end
         if (sel < 0) break;
         e = '0;
         while (!e[8] && mq[sel].size() > 0) begin
            e = mq[sel].pop_front();
            exp_q.push_back({sel[1:0], e[7:0]});
         end
         model_ptr = (sel + 1) % NREQ;
      end
   endtask

   task automatic wait_strobes(input string tag, input int target, input int bound);
      int k = 0;
      while (str_log.size() < target && k < bound) begin
         tick();
         k++;
      end
      check({tag, "_strobe_wait"}, 32'(str_log.size() >= target), 32'd1);
   endtask

   task automatic wait_drain(input string tag, input int bound);
      int k = 0;
      bit done = 1'b0;
      while (!done && k < bound) begin
         tick();
         k++;
         done = all_empty() && arb_busy === 1'b0 && tx_busy === 1'b0;
      end
      check({tag, "_drain"}, 32'(done), 32'd1);
   endtask

   task automatic compare_log(input string tag, input int base, input int rbase);
      int n;
      n = str_log.size() - base;
      check({tag, "_count"}, n, exp_q.size());
      check({tag, "_ready_pulses"}, rdy_cnt - rbase, exp_q.size());
      for (int j = 0; j < exp_q.size() && j < n; j++)
         check($sformatf("%s_byte%0d", tag, j), 32'(str_log[base + j]), 32'(exp_q[j]));
      exp_q.delete();
   endtask

   task automatic check_gaps(input string tag, input int base, input int gap);
      for (int j = base + 1; j < str_cyc.size(); j++)
         check($sformatf("%s_gap%0d", tag, j - base), str_cyc[j] - str_cyc[j-1], gap);
   endtask

   task automatic load_random(input int max_pk);
      int n, len;
      for (int i = 0; i < NREQ; i++) begin
         n = $urandom_range(max_pk, 0);
         for (int p = 0; p < n; p++) begin
            len = $urandom_range(3, 1);
            for (int b = 0; b < len; b++)
               drv_q[i].push_back({(b == len - 1), 8'($urandom)});
         end
      end
      if (all_empty()) drv_q[$urandom_range(NREQ-1, 0)].push_back({1'b1, 8'($urandom)});
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int i = 0; i < NREQ; i++) drv_q[i].delete();
      drive_reqs();
      @(posedge clock);
      #1 reset = 1'b0;
      model_ptr = 0;
   endtask

   int base, rbase, k;

   initial begin
      reset = 1'b1;
      abort = 1'b0;
      req_valid = '0;
      req_last = '0;
      req_data = '0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_tx_datain", tx_datain, 8'hFF);
      check("rst_strobe", tx_datain_ready, 1'b0);
      check("rst_ready", req_ready, 4'b0000);
      check("rst_arb_busy", arb_busy, 1'b0);
      check("rst_active_id", active_id, 2'd0);
      check("rst_tx_abort", tx_abort, 1'b0);
      reset = 1'b0;

      // single byte from requester 1
      base = str_log.size();
      rbase = rdy_cnt;
      drv_q[1].push_back({1'b1, 8'hA5});
      build_expect();
      drive_reqs();
      k = 0;
      do begin
         tick();
         k++;
      end while (s_ready === '0 && k < 10);
      check("t1_ready", s_ready, 4'b0010);
      check("t1_no_early_strobe", s_strobe, 1'b0);
      tick();
      check("t1_strobe", s_strobe, 1'b1);
      check("t1_data", s_data, 8'hA5);
      check("t1_active_id", s_active, 2'd1);
      check("t1_ready_pulse_end", s_ready, 4'b0000);
      tick();
      check("t1_strobe_end", s_strobe, 1'b0);
      wait_drain("t1", 60);
      check("t1_active_kept", active_id, 2'd1);
      check("t1_tx_datain_kept", tx_datain, 8'hA5);
      compare_log("t1", base, rbase);

      // 3-byte packet from requester 2 with 0 and 3 also pending
      base = str_log.size();
      rbase = rdy_cnt;
      drv_q[2].push_back({1'b0, 8'hB0});
      drv_q[2].push_back({1'b0, 8'hB1});
      drv_q[2].push_back({1'b1, 8'hB2});
      drv_q[0].push_back({1'b1, 8'hC0});
      drv_q[3].push_back({1'b1, 8'hD3});
      build_expect();
      drive_reqs();
      wait_strobes("t3", base + 5, 5 * (busy_len + 10));
      wait_drain("t3", 60);
      compare_log("t3", base, rbase);
      check_gaps("t3", base, busy_len + 3);

      // all four valid, single bytes, fairness from pointer 0
      do_reset();
      base = str_log.size();
      rbase = rdy_cnt;
      drv_q[0].push_back({1'b1, 8'h10});
      drv_q[0].push_back({1'b1, 8'h10});
      drv_q[1].push_back({1'b1, 8'h11});
      drv_q[2].push_back({1'b1, 8'h12});
      drv_q[3].push_back({1'b1, 8'h13});
      build_expect();
      drive_reqs();
      wait_strobes("t2", base + 5, 5 * (busy_len + 10));
      wait_drain("t2", 60);
      compare_log("t2", base, rbase);

      // abort during WAIT_DONE of the first byte of a locked packet
      do_reset();
      base = str_log.size();
      drv_q[2].push_back({1'b0, 8'h41});
      drv_q[2].push_back({1'b0, 8'h42});
      drv_q[2].push_back({1'b1, 8'h43});
      drive_reqs();
      wait_strobes("t4_first", base + 1, 20);
      check("t4_first_byte", 32'(str_log[base]), {22'd0, 2'd2, 8'h41});
      tick();
      drv_q[0].push_back({1'b1, 8'h50});
      drv_q[3].push_back({1'b1, 8'h60});
      drv_q[2].delete();
      abort = 1'b1;
      drive_reqs();
      tick();
      check("t4_tx_abort", s_abort, 1'b1);
      check("t4_ready_blocked", s_ready, 4'b0000);
      check("t4_busy_in_abort", s_arb_busy, 1'b1);
      abort = 1'b0;
      check("t4_datain_flushed", tx_datain, 8'hFF);
      check("t4_strobe_low", tx_datain_ready, 1'b0);
      check("t4_back_to_arb", arb_busy, 1'b0);
      wait_strobes("t4_after", base + 3, 3 * (busy_len + 10));
      wait_drain("t4", 80);
      check("t4_next_grant", 32'(str_log[base + 1]), {22'd0, 2'd0, 8'h50});
      check("t4_then", 32'(str_log[base + 2]), {22'd0, 2'd3, 8'h60});

      // transmitter never raises busy: random packets, fixed 5-cycle cadence
      do_reset();
      busy_len = 0;
      base = str_log.size();
      rbase = rdy_cnt;
      load_random(2);
      build_expect();
      drive_reqs();
      wait_drain("t5", 400);
      compare_log("t5", base, rbase);
      check_gaps("t5", base, 5);

      // random packets with random transmitter character time
      for (int r = 0; r < 3; r++) begin
         busy_len = $urandom_range(25, 1);
         base = str_log.size();
         rbase = rdy_cnt;
         load_random(3);
         build_expect();
         drive_reqs();
         wait_drain($sformatf("rnd%0d", r), 40 * (busy_len + 6) + 60);
         compare_log($sformatf("rnd%0d", r), base, rbase);
         check_gaps($sformatf("rnd%0d", r), base, busy_len + 3);
      end

`ifdef ARB_TIMEOUT_EN
      // requester 1 stalls inside a locked packet; HOLD times out after 16 cycles
      do_reset();
      busy_len = 4;
      base = str_log.size();
      k = evt_cnt;
      drv_q[1].push_back({1'b0, 8'h71});
      drv_q[2].push_back({1'b1, 8'h72});
      drive_reqs();
      wait_strobes("t6_first", base + 1, 20);
      check("t6_first_byte", 32'(str_log[base]), {22'd0, 2'd1, 8'h71});
      wait_strobes("t6_next", base + 2, 80);
      check("t6_evt_count", evt_cnt - k, 1);
      check("t6_evt_time", evt_cyc - str_cyc[base], busy_len + 18);
      check("t6_next_grant", 32'(str_log[base + 1]), {22'd0, 2'd2, 8'h72});
      wait_drain("t6", 60);
`endif

      check("never_strobe_while_busy", overlap_cnt, 0);
      check("ready_onehot", rdy_bad, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
